// File: rtl/xlr8_pcint_pkg.sv
// xlr8_pcint_pkg: shared constants and address-range helper for the pin-change port
package xlr8_pcint_pkg;

    localparam logic [7:0] DM_BASE    = 8'h60;
    localparam int         ARM_CYCLES = 3;

    // Registers at or above DM_BASE live in data memory rather than I/O space
    function automatic logic dm_loc(input logic [7:0] addr);
        return addr >= DM_BASE;
    endfunction

endpackage

// File: rtl/xlr8_pcint_filt.sv
// xlr8_pcint_filt: per-pin synchroniser, glitch filter and previous-level flop
//   clk, rstn  : clock, asynchronous active-low reset
//   pin        : raw asynchronous pad input
//   pcflt      : filter length in cycles (0 or 1 means no filtering)
//   pcflt_we   : filter length is being written; restarts the count
//   armed      : edge detection enabled; until then flt/prev follow pin_sync
//   flt, prev  : filtered level and its value one cycle earlier
module xlr8_pcint_filt #(
    parameter int FILT_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              pin,
    input  logic [FILT_W-1:0] pcflt,
    input  logic              pcflt_we,
    input  logic              armed,
    output logic              flt,
    output logic              prev
);

    logic [1:0]        sync;
    logic [FILT_W-1:0] cnt;
    logic              pin_sync;

    assign pin_sync = sync[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= '0;
            cnt  <= '0;
            flt  <= 1'b0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            // While arming, prev follows pin_sync too so a pin that is high
            // out of reset does not look like a fresh rising edge once armed.
            prev <= armed ? flt : pin_sync;
            if (!armed || pcflt <= FILT_W'(1)) begin
                flt <= pin_sync;
                cnt <= '0;
            end else if (pin_sync == flt) begin
                cnt <= '0;
            end else if (cnt == pcflt - 1'b1) begin
                flt <= pin_sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (pcflt_we) cnt <= '0;
        end
    end

endmodule

// File: rtl/xlr8_pcint_port.sv
// xlr8_pcint_port: filtered pin-change detector for one GPIO port, one-cycle pc_int pulse
//   clk, rstn        : clock, asynchronous active-low reset
//   adr, iowe, iore  : AVR I/O bus address and strobes
//   ramadr, ramwe,
//   ramre, dm_sel    : data-memory bus address, strobes and select
//   dbus_in/dbus_out : write data / read data (zero when not selected)
//   out_en           : one of this block's registers is being read
//   pin_in           : raw pad inputs
//   pc_int           : one-cycle pulse per cycle with an enabled edge
//   pin_state        : filtered pin levels
module xlr8_pcint_port
    import xlr8_pcint_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int FILT_W         = 4,
    parameter int PCRISE_Address = 0,
    parameter int PCFALL_Address = 0,
    parameter int PCFLT_Address  = 0,
    parameter int PCPIN_Address  = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [5:0]       adr,
    input  logic             iowe,
    input  logic             iore,
    input  logic [7:0]       dbus_in,
    output logic [7:0]       dbus_out,
    output logic             out_en,
    input  logic [7:0]       ramadr,
    input  logic             ramre,
    input  logic             ramwe,
    input  logic             dm_sel,
    input  logic [WIDTH-1:0] pin_in,
    output logic             pc_int,
    output logic [WIDTH-1:0] pin_state
);

    localparam logic [7:0] RISE_A = 8'(PCRISE_Address);
    localparam logic [7:0] FALL_A = 8'(PCFALL_Address);
    localparam logic [7:0] FLT_A  = 8'(PCFLT_Address);
    localparam logic [7:0] PIN_A  = 8'(PCPIN_Address);

    logic [WIDTH-1:0]  pcrise, pcfall, prev;
    logic [FILT_W-1:0] pcflt;
    logic [1:0]        arm;
    logic              armed;
    logic              rise_we, fall_we, flt_we;
    logic              rise_re, fall_re, flt_re, pin_re;

    function automatic logic sel(input logic [7:0] a, input logic [7:0] ra,
                                 input logic [5:0] ia, input logic ds,
                                 input logic dm_str, input logic io_str);
        return dm_loc(a) ? (ds && ra == a && dm_str) : (ia == a[5:0] && io_str);
    endfunction

    assign rise_we = sel(RISE_A, ramadr, adr, dm_sel, ramwe, iowe);
    assign fall_we = sel(FALL_A, ramadr, adr, dm_sel, ramwe, iowe);
    assign flt_we  = sel(FLT_A,  ramadr, adr, dm_sel, ramwe, iowe);
    assign rise_re = sel(RISE_A, ramadr, adr, dm_sel, ramre, iore);
    assign fall_re = sel(FALL_A, ramadr, adr, dm_sel, ramre, iore);
    assign flt_re  = sel(FLT_A,  ramadr, adr, dm_sel, ramre, iore);
    assign pin_re  = sel(PIN_A,  ramadr, adr, dm_sel, ramre, iore);

    assign out_en   = rise_re | fall_re | flt_re | pin_re;
    assign dbus_out = ({8{rise_re}} & 8'(pcrise)) | ({8{fall_re}} & 8'(pcfall)) |
                      ({8{flt_re}}  & 8'(pcflt))  | ({8{pin_re}}  & 8'(pin_state));

    assign armed = arm == 2'(ARM_CYCLES);

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        xlr8_pcint_filt #(.FILT_W(FILT_W)) u_filt (
            .clk      (clk),
            .rstn     (rstn),
            .pin      (pin_in[i]),
            .pcflt    (pcflt),
            .pcflt_we (flt_we),
            .armed    (armed),
            .flt      (pin_state[i]),
            .prev     (prev[i])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcrise <= '0;
            pcfall <= '0;
            pcflt  <= '0;
            arm    <= '0;
            pc_int <= 1'b0;
        end else begin
            if (rise_we) pcrise <= dbus_in[WIDTH-1:0];
            if (fall_we) pcfall <= dbus_in[WIDTH-1:0];
            if (flt_we)  pcflt  <= dbus_in[FILT_W-1:0];
            if (!armed)  arm    <= arm + 2'd1;
            // Enables are sampled before any same-cycle write lands
            pc_int <= armed && |((pin_state & ~prev & pcrise) | (~pin_state & prev & pcfall));
        end
    end

endmodule

// File: tb/tb_xlr8_pcint_port.sv
module tb_xlr8_pcint_port;

    localparam logic [7:0] A_RISE = 8'h20;
    localparam logic [7:0] A_FALL = 8'h21;
    localparam logic [7:0] A_PIN  = 8'h22;
    localparam logic [7:0] A_FLT  = 8'h70;

    logic       clk = 1'b0, rstn = 1'b1;
    logic [5:0] adr = '0;
    logic       iowe = 1'b0, iore = 1'b0;
    logic [7:0] dbus_in = '0, dbus_out;
    logic       out_en;
    logic [7:0] ramadr = '0;
    logic       ramre = 1'b0, ramwe = 1'b0, dm_sel = 1'b0;
    logic [7:0] pin_in = 8'hFF;
    logic       pc_int;
    logic [7:0] pin_state;

    int         cyc = 0, n_cmp = 0, n_bad = 0;
    int         pulse_q[$];
    logic [7:0] rd_q[$];
    string      rd_name[$];

    xlr8_pcint_port #(
        .WIDTH(8), .FILT_W(4),
        .PCRISE_Address(32'h20), .PCFALL_Address(32'h21),
        .PCFLT_Address(32'h70),  .PCPIN_Address(32'h22)
    ) dut (
        .clk(clk), .rstn(rstn), .adr(adr), .iowe(iowe), .iore(iore),
        .dbus_in(dbus_in), .dbus_out(dbus_out), .out_en(out_en),
        .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe), .dm_sel(dm_sel),
        .pin_in(pin_in), .pc_int(pc_int), .pin_state(pin_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expectations whenever the DUT presents a read or a pulse
    always @(posedge clk) begin
        #1;
        if (out_en) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read: out_en=1 dbus_out=%h, no read expected (cyc %0d)", dbus_out, cyc);
            end else begin
                logic [7:0] e;
                string nm;
                e  = rd_q.pop_front();
                nm = rd_name.pop_front();
                if (dbus_out !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h (cyc %0d)", nm, dbus_out, e, cyc);
                end
            end
        end
        if (pc_int) begin
            n_cmp++;
            if (pulse_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: pc_int=1 at cyc %0d, none expected", cyc);
            end else begin
                int e;
                e = pulse_q.pop_front();
                if (cyc != e) begin
                    n_bad++;
                    $display("FAIL pulse_time: pc_int at cyc %0d expected cyc %0d", cyc, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        dbus_in = d;
        if (a >= 8'h60) begin
            ramadr = a; dm_sel = 1'b1; ramwe = 1'b1;
        end else begin
            adr = a[5:0]; iowe = 1'b1;
        end
        @(negedge clk);
        ramwe = 1'b0; dm_sel = 1'b0; iowe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
        @(negedge clk);
        rd_q.push_back(e);
        rd_name.push_back(nm);
        if (a >= 8'h60) begin
            ramadr = a; dm_sel = 1'b1; ramre = 1'b1;
        end else begin
            adr = a[5:0]; iore = 1'b1;
        end
        @(negedge clk);
        ramre = 1'b0; dm_sel = 1'b0; iore = 1'b0;
    endtask

    // Drive pins; lat>0 schedules an expected pulse lat cycles later
    task automatic pin_set(input logic [7:0] p, input int lat);
        @(negedge clk);
        pin_in = p;
        if (lat > 0) pulse_q.push_back(cyc + lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rstn = 1'b0;
        tick(3);
        rstn = 1'b1;
        // reset values, then enable every edge with all pins high from reset
        rd(A_RISE, 8'h00, "rst_pcrise");
        rd(A_FALL, 8'h00, "rst_pcfall");
        rd(A_FLT,  8'h00, "rst_pcflt");
        wr(A_RISE, 8'hFF);
        wr(A_FALL, 8'hFF);
        rd(A_PIN,  8'hFF, "arm_pcpin");
        rd(A_RISE, 8'hFF, "pcrise_rb");
        tick(4);
        // single rising edge, no filter
        wr(A_RISE, 8'h00);
        wr(A_FALL, 8'h00);
        pin_set(8'h00, 0);
        tick(6);
        rd(A_PIN, 8'h00, "pins_low");
        wr(A_RISE, 8'h01);
        pin_set(8'h01, 4);
        tick(8);
        pin_set(8'h00, 0);
        tick(8);
        // glitch filter of 5 cycles, falling edge on pin 2
        wr(A_RISE, 8'h00);
        wr(A_FLT, 8'h05);
        rd(A_FLT, 8'h05, "pcflt_rb");
        wr(A_FALL, 8'h04);
        pin_set(8'h04, 0);
        tick(12);
        rd(A_PIN, 8'h04, "pin2_high");
        pin_set(8'h00, 0);
        tick(3);
        pin_set(8'h04, 0);
        tick(12);
        rd(A_PIN, 8'h04, "glitch_dropped");
        pin_set(8'h00, 8);
        tick(14);
        rd(A_PIN, 8'h00, "pin2_filtered_low");
        wr(A_FLT, 8'h00);
        // simultaneous and back-to-back rises
        wr(A_FALL, 8'h00);
        wr(A_RISE, 8'h03);
        pin_set(8'h03, 4);
        tick(6);
        pin_set(8'h00, 0);
        tick(6);
        pin_set(8'h01, 4);
        pin_set(8'h03, 4);
        tick(8);
        // data-memory mapped PCFLT; I/O alias of its low bits must not hit
        wr(A_FLT, 8'hFF);
        rd(A_FLT, 8'h0F, "dm_pcflt");
        wr(8'h30, 8'h03);
        rd(A_FLT, 8'h0F, "io_alias_ignored");
        @(negedge clk);
        adr = 6'h30; iore = 1'b1;
        @(negedge clk);
        iore = 1'b0;
        // reset in the middle of a filter count
        wr(A_FLT, 8'h00);
        pin_set(8'h00, 0);
        tick(6);
        wr(A_FLT, 8'h06);
        wr(A_RISE, 8'h01);
        pin_set(8'h01, 0);
        tick(3);
        @(negedge clk);
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        rd(A_RISE, 8'h00, "rst2_pcrise");
        rd(A_FLT,  8'h00, "rst2_pcflt");
        tick(2);
        rd(A_PIN,  8'h01, "rst2_pcpin");
        wr(A_RISE, 8'h01);
        pin_set(8'h00, 0);
        tick(6);
        pin_set(8'h01, 4);
        tick(10);
        while (pulse_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_pulse: no pc_int, expected at cyc %0d", pulse_q.pop_front());
        end
        while (rd_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_read %s: out_en never rose, expected data %h", rd_name.pop_front(), rd_q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xlr8_pcint_port.md
Name: xlr8_pcint_port

Overview:
- Upstream pin-change detector for one GPIO port of WIDTH pins.
- Synchronises the raw pins and applies a programmable glitch filter to each pin.
- Detects rising and/or falling edges per pin and emits a one-cycle pc_int pulse.
- pc_int drives one bit of the x_int_in vector on xlr8_pcint. Software configures the block through AVR I/O or data-memory registers.

Parameters:
- WIDTH, 8: pins per port, 1..8.
- FILT_W, 4: filter counter width; maximum filter length is 2^FILT_W-1 cycles.
- PCRISE_Address, 0: rising-edge enable register address.
- PCFALL_Address, 0: falling-edge enable register address.
- PCFLT_Address, 0: filter length register address.
- PCPIN_Address, 0: filtered pin state register address, read-only.

Ports:
- clk, input, 1: clock.
- rstn, input, 1: reset, asynchronous, active-low.
- adr, input, 6: I/O address.
- iowe, input, 1: I/O write strobe.
- iore, input, 1: I/O read strobe.
- dbus_in, input, 8: write data.
- dbus_out, output, 8: read data; zero when not selected.
- out_en, output, 1: high while any register of this block is being read.
- ramadr, input, 8: data-memory address.
- ramre, input, 1: data-memory read strobe.
- ramwe, input, 1: data-memory write strobe.
- dm_sel, input, 1: data-memory select.
- pin_in, input, WIDTH: raw asynchronous pad inputs.
- pc_int, output, 1: one-cycle pin-change pulse, to xlr8_pcint x_int_in[n].
- pin_state, output, WIDTH: filtered pin levels.

Behaviour:
- Address decode:
  - Address >= 8'h60: register uses dm_sel && ramadr match, with ramwe/ramre.
  - Otherwise: register uses adr == Address[5:0], with iowe/iore.
  - out_en is the OR of all four read selects; dbus_out is the OR of the selected registers, zero-extended to 8 bits.
- Reset values: pcrise=0, pcfall=0, pcflt=0; sync and filter flops=0; pc_int=0; pin_state=0; arm counter=0.
- Register writes take effect on the next clk edge.
  - PCPIN writes are ignored.
  - PCFLT stores dbus_in[FILT_W-1:0]; reads return zeros above FILT_W.
  - A PCFLT write clears every filter counter in the same cycle.
- Synchroniser: 2 flops per pin, giving pin_sync.
- Filter, per pin, with counter cnt and filtered level flt:
  - pcflt==0 or 1: flt <= pin_sync every cycle.
  - Otherwise, when pin_sync==flt: cnt <= 0.
  - Otherwise, when cnt==pcflt-1: flt <= pin_sync and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Net effect: a new level must be present on pin_sync for pcflt consecutive cycles before it is accepted. Shorter glitches are dropped; cnt never wraps.
- Arming:
  - A 2-bit arm counter counts from 0 to 3 after reset, then saturates.
  - Until the arm counter reaches 3, flt tracks pin_sync directly and edge detection is suppressed. This prevents a spurious interrupt on pins that are high at reset.
- Edge detect:
  - prev <= flt every cycle.
  - rise = flt & ~prev & pcrise.
  - fall = ~flt & prev & pcfall.
  - pc_int <= armed & |(rise|fall). pc_int is registered and high for exactly one cycle per event cycle.
- Latency, pcflt=0: a pin change sampled at edge k gives pin_sync at k+1, flt at k+2 and pc_int high after edge k+3.
  - Each additional filter cycle adds 1 clk when pcflt>=2.
- Simultaneous events:
  - Several pins changing in one cycle produce one pulse.
  - Changes in back-to-back cycles produce back-to-back pulses; downstream ORs them into its flag.
- An edge whose enable bit is cleared in the same cycle uses the old enable value (register value before the write).
- pin_state = flt. It is visible through PCPIN; bits above WIDTH read 0.
- Reset asserted mid-filter or mid-pulse clears everything immediately and re-runs arming.

Decomposition:
- Package xlr8_pcint_pkg:
  - DM_BASE = 8'h60.
  - ARM_CYCLES = 3.
  - Function dm_loc(addr) returning the address-range decision.
- Sub-module xlr8_pcint_filt:
  - Contains the synchroniser, filter counter, flt and prev for one pin.
  - Inputs: pcflt, pcflt_we, armed.
  - Generated WIDTH times.
- The top level holds the registers, decode, edge combine and pc_int flop.

Test Plan:
- Reset with pin_in=8'hFF, pcrise=pcfall=8'hFF written after reset -> pc_int stays 0; PCPIN reads 8'hFF after 4 clks.
- pcrise=8'h01, pcflt=0, pin_in[0] 0->1 -> pc_int high for exactly 1 clk, 3 clks after the sampling edge; a 1->0 change gives no pulse.
- pcflt=5, pcfall=8'h04: a 4-cycle low glitch on pin2 -> no pulse and PCPIN[2] stays 1; a 5-cycle low -> one pulse and PCPIN[2]=0.
- pcrise=8'h03, pins 0 and 1 rise in the same cycle -> single 1-clk pulse; pin1 rises again 1 clk after pin0 -> two consecutive pulse cycles.
- DM mapping with PCFLT_Address=8'h70, ramwe write 8'hFF -> reads back 8'h0F (FILT_W=4) with out_en=1; an iowe write on adr 6'h30 is ignored.
- rstn pulsed low during an active filter count -> cnt and flt cleared; no pulse until re-armed and a valid edge occurs.
